// File: rtl/mem_controller.sv
// Multi-channel arbiter: routes per-LSU read/write requests onto NUM_CHANNELS memory ports.
// Optional round-robin consumer search is enabled by defining MEM_CTRL_RR_EN (default: fixed priority).
module mem_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_addr,
  input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]             mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_addr,
  input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]             mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_write_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY
  } state_t;

  state_t                   state     [NUM_CHANNELS];
  logic [CW-1:0]            cur       [NUM_CHANNELS];
  logic                     grant_vld [NUM_CHANNELS];
  logic [CW-1:0]            grant_idx [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] eligible;
  logic [CW-1:0]            search_start;

`ifdef MEM_CTRL_RR_EN
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_next;
  logic          any_grant;

  assign search_start = rr_ptr;

  // Pointer moves past the highest consumer index granted this cycle.
  always_comb begin
    int hi;
    hi = -1;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (grant_vld[ch] && int'(grant_idx[ch]) > hi) hi = int'(grant_idx[ch]);
    end
    any_grant = (hi >= 0);
    rr_next   = (hi < 0 || hi + 1 >= NUM_CONSUMERS) ? '0 : CW'(hi + 1);
  end
`else
  assign search_start = '0;
`endif

  // A channel still in RELAY keeps its consumer claimed, so a same-cycle release never re-grants.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    claimed = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state[ch] != IDLE) claimed[cur[ch]] = 1'b1;
    end
    eligible = (consumer_read_valid | consumer_write_valid) & ~claimed;
  end

  // IDLE channels pick in ascending index; lower channels' picks are masked out for higher ones.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    int idx;
    taken = '0;
    idx   = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_vld[ch] = 1'b0;
      grant_idx[ch] = '0;
      if (state[ch] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = int'(search_start) + k;
          if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
          if (!grant_vld[ch] && eligible[idx] && !taken[idx]) begin
            grant_vld[ch] = 1'b1;
            grant_idx[ch] = CW'(idx);
            taken[idx]    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch] <= IDLE;
        cur[ch]   <= '0;
      end
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_addr        <= '0;
      mem_write_valid      <= '0;
      mem_write_addr       <= '0;
      mem_write_data       <= '0;
`ifdef MEM_CTRL_RR_EN
      rr_ptr               <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every channel sees the same pre-edge state.
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state[ch])
          IDLE: begin
            if (grant_vld[ch]) begin
              cur[ch] <= grant_idx[ch];
              if (consumer_read_valid[grant_idx[ch]]) begin
                mem_read_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] <=
                  consumer_read_addr[int'(grant_idx[ch])*ADDR_WIDTH +: ADDR_WIDTH];
                mem_read_valid[ch] <= 1'b1;
                state[ch]          <= READ_WAIT;
              end else begin
                mem_write_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] <=
                  consumer_write_addr[int'(grant_idx[ch])*ADDR_WIDTH +: ADDR_WIDTH];
                mem_write_data[ch*DATA_WIDTH +: DATA_WIDTH] <=
                  consumer_write_data[int'(grant_idx[ch])*DATA_WIDTH +: DATA_WIDTH];
                mem_write_valid[ch] <= 1'b1;
                state[ch]           <= WRITE_WAIT;
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[ch]) begin
              consumer_read_data[int'(cur[ch])*DATA_WIDTH +: DATA_WIDTH] <=
                mem_read_data[ch*DATA_WIDTH +: DATA_WIDTH];
              consumer_read_ready[cur[ch]] <= 1'b1;
              mem_read_valid[ch]           <= 1'b0;
              state[ch]                    <= READ_RELAY;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[ch]) begin
              consumer_write_ready[cur[ch]] <= 1'b1;
              mem_write_valid[ch]           <= 1'b0;
              state[ch]                     <= WRITE_RELAY;
            end
          end
          READ_RELAY: begin
            if (!consumer_read_valid[cur[ch]]) begin
              consumer_read_ready[cur[ch]] <= 1'b0;
              state[ch]                    <= IDLE;
            end
          end
          WRITE_RELAY: begin
            if (!consumer_write_valid[cur[ch]]) begin
              consumer_write_ready[cur[ch]] <= 1'b0;
              state[ch]                     <= IDLE;
            end
          end
          default: state[ch] <= IDLE;
        endcase
      end
`ifdef MEM_CTRL_RR_EN
      if (any_grant) rr_ptr <= rr_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: a 1-channel instance for directed timing/arbitration
// cases and a 4-channel instance for contention and randomized traffic against a memory model.
module tb_mem_controller;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NC = 8;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory content before any write.
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // ---------------- 4-channel instance ----------------
  logic [NC-1:0]    a_rv, a_rr, a_wv, a_wr;
  logic [NC*AW-1:0] a_ra, a_wa;
  logic [NC*DW-1:0] a_rd, a_wd;
  logic [NA-1:0]    a_mrv, a_mrr, a_mwv, a_mwr, a_go;
  logic [NA*AW-1:0] a_mra, a_mwa;
  logic [NA*DW-1:0] a_mrd, a_mwd;
  logic [7:0]       a_wm  [256];
  logic             a_wrt [256];
  logic [7:0]       a_exp [256];

  mem_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NA)) dut (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(a_rv), .consumer_read_addr(a_ra),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_addr(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_addr(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_addr(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  // Random-latency memory behind the 4 channels.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_go <= '0;
      for (int i = 0; i < 256; i++) a_wrt[i] <= 1'b0;
    end else begin
      a_go <= NA'($urandom);
      for (int ch = 0; ch < NA; ch++) begin
        if (a_mwv[ch] && a_mwr[ch]) begin
          a_wm[a_mwa[ch*AW +: AW]]  <= a_mwd[ch*DW +: DW];
          a_wrt[a_mwa[ch*AW +: AW]] <= 1'b1;
        end
      end
    end
  end

  for (genvar ch = 0; ch < NA; ch++) begin : g_a_mem
    assign a_mrr[ch] = a_mrv[ch] & a_go[ch];
    assign a_mwr[ch] = a_mwv[ch] & a_go[ch];
    assign a_mrd[ch*DW +: DW] = a_wrt[a_mra[ch*AW +: AW]] ? a_wm[a_mra[ch*AW +: AW]]
                                                         : init_val(a_mra[ch*AW +: AW]);
  end

  // Addresses on the 4-channel instance carry the consumer id in bits [2:0].
  logic [NC-1:0] mon_seen;
  logic [2:0]    mon_id;
  int            dup_cnt = 0;
  always @(negedge clk) begin
    mon_seen = '0;
    for (int ch = 0; ch < NA; ch++) begin
      if (a_mrv[ch] || a_mwv[ch]) begin
        mon_id = a_mrv[ch] ? a_mra[ch*AW +: 3] : a_mwa[ch*AW +: 3];
        if (mon_seen[mon_id]) dup_cnt++;
        mon_seen[mon_id] = 1'b1;
      end
    end
  end

  // ---------------- 1-channel instance ----------------
  logic [NC-1:0]    b_rv, b_rr, b_wv, b_wr;
  logic [NC*AW-1:0] b_ra, b_wa;
  logic [NC*DW-1:0] b_rd, b_wd;
  logic             b_mrv, b_mrr, b_mwv, b_mwr;
  logic [AW-1:0]    b_mra, b_mwa;
  logic [DW-1:0]    b_mrd, b_mwd;
  logic             b_rstall = 1'b0;
  logic             b_wstall = 1'b0;
  logic [7:0]       b_wm  [256];
  logic             b_wrt [256];
  logic [7:0]       b_exp [256];

  mem_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(b_rv), .consumer_read_addr(b_ra),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_addr(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_addr(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_addr(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // Zero-wait memory unless stalled by the bench.
  assign b_mrr = b_mrv & ~b_rstall;
  assign b_mwr = b_mwv & ~b_wstall;
  assign b_mrd = b_wrt[b_mra] ? b_wm[b_mra] : init_val(b_mra);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) b_wrt[i] <= 1'b0;
    end else if (b_mwv && b_mwr) begin
      b_wm[b_mwa]  <= b_mwd;
      b_wrt[b_mwa] <= 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic b_read(input int c, input logic [7:0] addr, input string tag);
    b_ra[c*AW +: AW] = addr;
    b_rv[c] = 1'b1;
    for (int i = 0; i < 50 && !b_rr[c]; i++) @(negedge clk);
    check({tag, "_ready"}, 32'(b_rr[c]), 32'd1);
    check({tag, "_data"}, 32'(b_rd[c*DW +: DW]), 32'(b_exp[addr]));
    b_rv[c] = 1'b0;
    @(negedge clk);
  endtask

  // Reference arbiter: first valid consumer at or after ptr, wrapping.
  function automatic int arb_pick(input logic [NC-1:0] v, input int ptr);
    for (int k = 0; k < NC; k++) begin
      if (v[(ptr + k) % NC]) return (ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic run_random(input int cycles);
    logic       busy [NC];
    logic       isrd [NC];
    logic [7:0] addr [NC];
    logic [7:0] wdat [NC];
    int         waitc[NC];
    int         nbusy;
    for (int c = 0; c < NC; c++) begin
      busy[c] = 1'b0; isrd[c] = 1'b0; addr[c] = '0; wdat[c] = '0; waitc[c] = 0;
    end
    for (int t = 0; t < cycles + 600; t++) begin
      @(negedge clk);
      nbusy = 0;
      for (int c = 0; c < NC; c++) begin
        if (busy[c]) begin
          if (isrd[c] && a_rr[c]) begin
            check("rand_rd_data", 32'(a_rd[c*DW +: DW]), 32'(a_exp[addr[c]]));
            a_rv[c] = 1'b0;
            busy[c] = 1'b0;
          end else if (!isrd[c] && a_wr[c]) begin
            a_exp[addr[c]] = wdat[c];
            a_wv[c] = 1'b0;
            busy[c] = 1'b0;
          end else if (++waitc[c] > 300) begin
            check("rand_timeout", 32'(waitc[c]), 32'd300);
            a_rv[c] = 1'b0; a_wv[c] = 1'b0; busy[c] = 1'b0;
          end
        end else if (t < cycles && !a_rr[c] && !a_wr[c] && $urandom_range(0, 2) == 0) begin
          addr[c]  = {5'($urandom), 3'(c)};
          isrd[c]  = 1'($urandom_range(0, 1));
          waitc[c] = 0;
          busy[c]  = 1'b1;
          if (isrd[c]) begin
            a_ra[c*AW +: AW] = addr[c];
            a_rv[c] = 1'b1;
          end else begin
            wdat[c] = 8'($urandom);
            a_wa[c*AW +: AW] = addr[c];
            a_wd[c*DW +: DW] = wdat[c];
            a_wv[c] = 1'b1;
          end
        end
        if (busy[c]) nbusy++;
      end
      if (t >= cycles && nbusy == 0) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NC-1:0] prev_v;
    logic          prev_mrv;
    logic [NC-1:0] served;
    int            grants, ptr, exp_c, pulses, mism;

    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
    b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
    for (int i = 0; i < 256; i++) begin
      a_exp[i] = init_val(8'(i));
      b_exp[i] = init_val(8'(i));
    end

    repeat (2) @(negedge clk);
    check("reset_a_mem_rd_valid", 32'(a_mrv), 32'd0);
    check("reset_a_mem_wr_valid", 32'(a_mwv), 32'd0);
    check("reset_a_cons_rd_ready", 32'(a_rr), 32'd0);
    check("reset_a_cons_rd_data", a_rd[31:0], 32'd0);
    check("reset_b_mem_rd_addr", 32'(b_mra), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read with zero-wait memory: consumer 3, addr 0x10 -> 0xA5.
    b_ra[3*AW +: AW] = 8'h10;
    b_rv[3] = 1'b1;
    @(negedge clk);
    check("rd1_mem_valid", 32'(b_mrv), 32'd1);
    check("rd1_mem_addr", 32'(b_mra), 32'h10);
    check("rd1_ready_early", 32'(b_rr[3]), 32'd0);
    @(negedge clk);
    check("rd1_ready", 32'(b_rr[3]), 32'd1);
    check("rd1_data", 32'(b_rd[3*DW +: DW]), 32'hA5);
    check("rd1_mem_valid_drop", 32'(b_mrv), 32'd0);
    b_rv[3] = 1'b0;
    b_ra[4*AW +: AW] = 8'h11;
    b_rv[4] = 1'b1;
    @(negedge clk);
    check("rd1_release", 32'(b_rr[3]), 32'd0);
    check("rd1_data_held", 32'(b_rd[3*DW +: DW]), 32'hA5);
    @(negedge clk);
    check("regrant_mem_valid", 32'(b_mrv), 32'd1);
    check("regrant_mem_addr", 32'(b_mra), 32'h11);
    b_rv[4] = 1'b0;
    repeat (3) @(negedge clk);

    // Write with memory stalled: address/data must hold, ready pulses once.
    b_wstall = 1'b1;
    b_wa[0*AW +: AW] = 8'h22;
    b_wd[0*DW +: DW] = 8'h7E;
    b_wv[0] = 1'b1;
    @(negedge clk);
    check("wr_mem_valid", 32'(b_mwv), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_addr", 32'(b_mwa), 32'h22);
      check("wr_hold_data", 32'(b_mwd), 32'h7E);
      check("wr_no_early_ready", 32'(b_wr[0]), 32'd0);
      @(negedge clk);
    end
    b_wstall = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_wr[0]) begin
        pulses++;
        b_wv[0] = 1'b0;
      end
    end
    check("wr_ready_pulses", 32'(pulses), 32'd1);
    b_exp[8'h22] = 8'h7E;
    b_read(1, 8'h22, "wr_readback");

    // Read and write on the same consumer: read goes first.
    b_rstall = 1'b1;
    b_ra[2*AW +: AW] = 8'h01;
    b_wa[2*AW +: AW] = 8'h02;
    b_wd[2*DW +: DW] = 8'h3C;
    b_rv[2] = 1'b1;
    b_wv[2] = 1'b1;
    @(negedge clk);
    check("rw_read_first", 32'(b_mrv), 32'd1);
    check("rw_read_addr", 32'(b_mra), 32'h01);
    check("rw_no_write_yet", 32'(b_mwv), 32'd0);
    b_rstall = 1'b0;
    for (int i = 0; i < 20 && !b_rr[2]; i++) @(negedge clk);
    check("rw_read_ready", 32'(b_rr[2]), 32'd1);
    check("rw_read_data", 32'(b_rd[2*DW +: DW]), 32'(b_exp[8'h01]));
    check("rw_write_pending", 32'(b_wr[2]), 32'd0);
    b_rv[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw_write_valid", 32'(b_mwv), 32'd1);
    check("rw_write_addr", 32'(b_mwa), 32'h02);
    check("rw_write_data", 32'(b_mwd), 32'h3C);
    for (int i = 0; i < 20 && !b_wr[2]; i++) @(negedge clk);
    check("rw_write_ready", 32'(b_wr[2]), 32'd1);
    b_wv[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while a read is waiting on memory.
    b_rstall = 1'b1;
    b_ra[1*AW +: AW] = 8'h33;
    b_rv[1] = 1'b1;
    @(negedge clk);
    check("rst_pre_mem_valid", 32'(b_mrv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_rd_valid", 32'(b_mrv), 32'd0);
    check("rst_mem_wr_valid", 32'(b_mwv), 32'd0);
    check("rst_cons_rd_ready", 32'(b_rr), 32'd0);
    check("rst_cons_wr_ready", 32'(b_wr), 32'd0);
    check("rst_a_mem_valid", 32'({a_mrv, a_mwv}), 32'd0);
    b_rv[1] = 1'b0;
    b_rstall = 1'b0;
    for (int i = 0; i < 256; i++) b_exp[i] = init_val(8'(i));
    @(negedge clk);
    rst_n = 1'b1;

    // Arbitration on the 1-channel instance: consumers 0 and 5 held valid.
    b_ra[0*AW +: AW] = 8'h40;
    b_ra[5*AW +: AW] = 8'h45;
    b_rv[0] = 1'b1;
    b_rv[5] = 1'b1;
    prev_v = b_rv;
    prev_mrv = b_mrv;
    grants = 0;
    ptr = 0;
    for (int t = 0; t < 80 && grants < 4; t++) begin
      @(negedge clk);
      if (b_mrv && !prev_mrv) begin
        exp_c = arb_pick(prev_v, ptr);
        check("arb_grant", 32'(b_mra - 8'h40), 32'(exp_c));
`ifdef MEM_CTRL_RR_EN
        ptr = (exp_c + 1) % NC;
`endif
        grants++;
      end
      for (int c = 0; c < NC; c += 5) begin
        if (b_rr[c]) begin
          check("arb_data", 32'(b_rd[c*DW +: DW]), 32'(b_exp[8'h40 + 8'(c)]));
          b_rv[c] = 1'b0;
        end else if (!b_rv[c]) begin
          b_rv[c] = 1'b1;
        end
      end
      prev_mrv = b_mrv;
      prev_v = b_rv;
    end
    check("arb_grant_count", 32'(grants), 32'd4);
    b_rv = '0;
    repeat (6) @(negedge clk);
    b_read(6, 8'h5D, "post_reset_read");

    // Contention: all 8 consumers read at once on 4 channels.
    for (int c = 0; c < NC; c++) a_ra[c*AW +: AW] = 8'h80 + 8'(c);
    a_rv = '1;
    @(negedge clk);
    check("cont_all_channels", 32'(a_mrv), 32'hF);
    for (int ch = 0; ch < NA; ch++) check("cont_channel_addr", 32'(a_mra[ch*AW +: AW]), 32'h80 + 32'(ch));
    served = '0;
    for (int t = 0; t < 400 && served != '1; t++) begin
      for (int c = 0; c < NC; c++) begin
        if (a_rv[c] && a_rr[c]) begin
          check("cont_data", 32'(a_rd[c*DW +: DW]), 32'(a_exp[8'h80 + 8'(c)]));
          a_rv[c] = 1'b0;
          served[c] = 1'b1;
        end
      end
      @(negedge clk);
    end
    check("cont_all_served", 32'(served), 32'hFF);
    repeat (3) @(negedge clk);

    // Randomized mixed traffic against the memory model.
    run_random(1500);
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      if ((a_wrt[i] ? a_wm[i] : init_val(8'(i))) !== a_exp[i]) mism++;
    end
    check("rand_mem_image", 32'(mism), 32'd0);
    check("no_dual_service", 32'(dup_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
